// File: rtl/interrupt_ctrl.sv
// interrupt_ctrl: IF/IE registers, IME master-enable state machine with EI delay, and
// a fixed-priority encoder for the five interrupt sources. The encoder output feeds
// the PC block.
//
// Sources: bit0 VBlank, bit1 STAT, bit2 Timer, bit3 Serial, bit4 Joypad.
//
// Ports:
//   clock, reset          system clock; asynchronous active-low reset
//   int_src[4:0]          one-cycle request pulses, set IF bits
//   addr_bus, data_in,    CPU register access to IF (0xFF0F) and IE (0xFFFF)
//   write_en
//   data_out, reg_sel     combinational read data / register-hit flag
//   ei, di, reti          instruction strobes driving IME
//   instr_boundary        last cycle of each instruction
//   int_request, int_ack  dispatch handshake with the control unit
//   int_pc_out[2:0]       vector index (address 0x0040 + 8*index)
//   ime                   master-enable status
//   halt_wake             HALT exit condition
//
// Build option: define INT_HALT_WAKE_EN to drive halt_wake from pending interrupts
// (independent of IME). Otherwise halt_wake is tied low.
module interrupt_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  int_src,
    input  logic [15:0] addr_bus,
    input  logic [7:0]  data_in,
    input  logic        write_en,
    output logic [7:0]  data_out,
    output logic        reg_sel,
    input  logic        ei,
    input  logic        di,
    input  logic        reti,
    input  logic        instr_boundary,
    output logic        int_request,
    input  logic        int_ack,
    output logic [2:0]  int_pc_out,
    output logic        ime,
    output logic        halt_wake
);

    localparam logic [15:0] AddrIf = 16'hFF0F;
    localparam logic [15:0] AddrIe = 16'hFFFF;

    typedef enum logic [1:0] {
        ImeOff,
        EiDelay,
        ImeOn,
        Dispatch
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  if_q, if_d;
    logic [7:0]  ie_q;
    logic [2:0]  idx_q;
    logic [4:0]  pending;
    logic [2:0]  win_idx;
    logic        sel_if, sel_ie;
    logic        ack_clr;
    logic        take_dispatch;

    assign sel_if  = (addr_bus == AddrIf);
    assign sel_ie  = (addr_bus == AddrIe);
    assign reg_sel = sel_if | sel_ie;

    always_comb begin
        data_out = 8'h00;
        if (sel_if) begin
            data_out = {3'b111, if_q};
        end else if (sel_ie) begin
            data_out = ie_q;
        end
    end

    assign pending = ie_q[4:0] & if_q;

    // Lowest set bit wins: scan from the top so lower indices overwrite.
    always_comb begin
        win_idx = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (pending[i]) begin
                win_idx = 3'(i);
            end
        end
    end

    assign ack_clr       = (state_q == Dispatch) && int_ack;
    assign take_dispatch = (state_q == ImeOn) && !di && instr_boundary && (pending != 5'd0);

    // Write first, then ack clear, then new requests so a pulse is never lost.
    always_comb begin
        if_d = if_q;
        if (write_en && sel_if) begin
            if_d = data_in[4:0];
        end
        if (ack_clr) begin
            if_d = if_d & ~(5'b00001 << idx_q);
        end
        if_d = if_d | int_src;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            if_q  <= 5'd0;
            ie_q  <= 8'h00;
            idx_q <= 3'd0;
        end else begin
            if_q <= if_d;
            if (write_en && sel_ie) begin
                ie_q <= data_in;
            end
            // Index is frozen for the whole dispatch and held afterwards.
            if (take_dispatch) begin
                idx_q <= win_idx;
            end
        end
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ImeOff;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; di has priority over every other event.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ImeOff: begin
                if (di) begin
                    state_d = ImeOff;
                end else if (ei) begin
                    state_d = EiDelay;
                end else if (reti) begin
                    state_d = ImeOn;
                end
            end
            EiDelay: begin
                if (di) begin
                    state_d = ImeOff;
                end else if (instr_boundary) begin
                    state_d = ImeOn;
                end
            end
            ImeOn: begin
                if (di) begin
                    state_d = ImeOff;
                end else if (take_dispatch) begin
                    state_d = Dispatch;
                end
            end
            Dispatch: begin
                // Instruction strobes are ignored until the control unit acks.
                if (int_ack) begin
                    state_d = ImeOff;
                end
            end
            default: state_d = ImeOff;
        endcase
    end

    // Outputs
    always_comb begin
        int_request = (state_q == Dispatch);
        ime         = (state_q == ImeOn) || (state_q == Dispatch);
    end

    assign int_pc_out = idx_q;

`ifdef INT_HALT_WAKE_EN
    assign halt_wake = |pending;
`else
    assign halt_wake = 1'b0;
`endif

endmodule

// File: tb/tb_interrupt_ctrl.sv
module tb_interrupt_ctrl;

    localparam logic [15:0] A_IF = 16'hFF0F;
    localparam logic [15:0] A_IE = 16'hFFFF;
`ifdef INT_HALT_WAKE_EN
    localparam bit HW = 1'b1;
`else
    localparam bit HW = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  int_src = '0;
    logic [15:0] addr_bus = A_IF;
    logic [7:0]  data_in = '0;
    logic        write_en = 1'b0;
    logic [7:0]  data_out;
    logic        reg_sel;
    logic        ei = 1'b0, di = 1'b0, reti = 1'b0, instr_boundary = 1'b0;
    logic        int_request;
    logic        int_ack = 1'b0;
    logic [2:0]  int_pc_out;
    logic        ime;
    logic        halt_wake;

    interrupt_ctrl dut (
        .clock          (clock),
        .reset          (reset),
        .int_src        (int_src),
        .addr_bus       (addr_bus),
        .data_in        (data_in),
        .write_en       (write_en),
        .data_out       (data_out),
        .reg_sel        (reg_sel),
        .ei             (ei),
        .di             (di),
        .reti           (reti),
        .instr_boundary (instr_boundary),
        .int_request    (int_request),
        .int_ack        (int_ack),
        .int_pc_out     (int_pc_out),
        .ime            (ime),
        .halt_wake      (halt_wake)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  din;
        logic        we, ei, di, reti, bnd, ack;
        logic [4:0]  src;
        logic [7:0]  dout;
        logic        sel, req;
        logic [2:0]  pc;
        logic        ime, halt;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Expected outputs describe the cycle in which the row's inputs are driven
    // (state before the next rising edge).
    function automatic vec_t v(input logic [15:0] a, input logic [7:0] d,
                               input logic we_, ei_, di_, reti_, bnd_, ack_,
                               input logic [4:0] src_, input logic [7:0] dout_,
                               input logic req_, input logic [2:0] pc_,
                               input logic ime_, input logic pend_);
        vec_t r;
        r.addr = a;   r.din = d;    r.we = we_;   r.ei = ei_;  r.di = di_;
        r.reti = reti_; r.bnd = bnd_; r.ack = ack_; r.src = src_;
        r.dout = dout_; r.req = req_; r.pc = pc_; r.ime = ime_;
        r.sel  = (a == A_IF) || (a == A_IE);
        r.halt = HW & pend_;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        addr_bus = A_IF; data_in = '0; write_en = 0; ei = 0; di = 0; reti = 0;
        instr_boundary = 0; int_ack = 0; int_src = '0;
    endtask

    task automatic apply(input vec_t r, input string tag);
        vec_t e;
        @(negedge clock);
        addr_bus = r.addr; data_in = r.din; write_en = r.we; ei = r.ei; di = r.di;
        reti = r.reti; instr_boundary = r.bnd; int_ack = r.ack; int_src = r.src;
        exp_q.push_back(r);
        #2;
        e = exp_q.pop_front();
        check({tag, " data_out"}, 32'(data_out), 32'(e.dout));
        check({tag, " reg_sel"}, 32'(reg_sel), 32'(e.sel));
        check({tag, " int_request"}, 32'(int_request), 32'(e.req));
        check({tag, " int_pc_out"}, 32'(int_pc_out), 32'(e.pc));
        check({tag, " ime"}, 32'(ime), 32'(e.ime));
        check({tag, " halt_wake"}, 32'(halt_wake), 32'(e.halt));
    endtask

    initial begin
        bit got;

        //                 addr  din   we ei di rt bd ak src    dout  rq pc  im pd
        // Reset values, IE write, EI delay, Timer dispatch and ack
        tbl.push_back(v(A_IE, 8'h00, 0, 0, 0, 0, 0, 0, 5'h00, 8'h00, 0, 3'd0, 0, 0));
        tbl.push_back(v(A_IF, 8'h00, 0, 0, 0, 0, 0, 0, 5'h00, 8'hE0, 0, 3'd0, 0, 0));
        tbl.push_back(v(A_IE, 8'h1F, 1, 0, 0, 0, 0, 0, 5'h00, 8'h00, 0, 3'd0, 0, 0));
        tbl.push_back(v(A_IE, 8'h00, 0, 0, 0, 0, 0, 0, 5'h00, 8'h1F, 0, 3'd0, 0, 0));
        tbl.push_back(v(A_IF, 8'h00, 0, 1, 0, 0, 0, 0, 5'h00, 8'hE0, 0, 3'd0, 0, 0));
        tbl.push_back(v(A_IF, 8'h00, 0, 0, 0, 0, 1, 0, 5'h00, 8'hE0, 0, 3'd0, 0, 0));
        tbl.push_back(v(A_IF, 8'h00, 0, 0, 0, 0, 1, 0, 5'h00, 8'hE0, 0, 3'd0, 1, 0));
        tbl.push_back(v(A_IF, 8'h00, 0, 0, 0, 0, 0, 0, 5'h04, 8'hE0, 0, 3'd0, 1, 0));
        tbl.push_back(v(A_IF, 8'h00, 0, 0, 0, 0, 1, 0, 5'h00, 8'hE4, 0, 3'd0, 1, 1));
        tbl.push_back(v(A_IF, 8'h00, 0, 0, 0, 0, 0, 0, 5'h00, 8'hE4, 1, 3'd2, 1, 1));
        tbl.push_back(v(A_IF, 8'h00, 0, 0, 0, 0, 0, 1, 5'h00, 8'hE4, 1, 3'd2, 1, 1));
        tbl.push_back(v(A_IF, 8'h00, 0, 0, 0, 0, 0, 0, 5'h00, 8'hE0, 0, 3'd2, 0, 0));
        // Priority among IF=1A/IE=18, index frozen across an IE write
        tbl.push_back(v(A_IF, 8'h1A, 1, 0, 0, 0, 0, 0, 5'h00, 8'hE0, 0, 3'd2, 0, 0));
        tbl.push_back(v(A_IE, 8'h18, 1, 0, 0, 0, 0, 0, 5'h00, 8'h1F, 0, 3'd2, 0, 1));
        tbl.push_back(v(A_IF, 8'h00, 0, 0, 0, 1, 0, 0, 5'h00, 8'hFA, 0, 3'd2, 0, 1));
        tbl.push_back(v(A_IF, 8'h00, 0, 0, 0, 0, 1, 0, 5'h00, 8'hFA, 0, 3'd2, 1, 1));
        tbl.push_back(v(A_IE, 8'h10, 1, 0, 0, 0, 0, 0, 5'h00, 8'h18, 1, 3'd3, 1, 1));
        tbl.push_back(v(A_IF, 8'h00, 0, 0, 0, 0, 0, 0, 5'h00, 8'hFA, 1, 3'd3, 1, 1));
        tbl.push_back(v(A_IF, 8'h00, 0, 0, 0, 0, 0, 1, 5'h00, 8'hFA, 1, 3'd3, 1, 1));
        tbl.push_back(v(A_IF, 8'h00, 0, 0, 0, 0, 0, 0, 5'h00, 8'hF2, 0, 3'd3, 0, 1));
        // EI followed by DI: IME never comes on
        tbl.push_back(v(A_IF, 8'h00, 0, 1, 0, 0, 0, 0, 5'h00, 8'hF2, 0, 3'd3, 0, 1));
        tbl.push_back(v(A_IF, 8'h00, 0, 0, 1, 0, 0, 0, 5'h00, 8'hF2, 0, 3'd3, 0, 1));
        for (int i = 0; i < 4; i++)
            tbl.push_back(v(A_IF, 8'h00, 0, 0, 0, 0, 1, 0, 5'h00, 8'hF2, 0, 3'd3, 0, 1));
        tbl.push_back(v(A_IF, 8'h00, 0, 0, 0, 0, 0, 0, 5'h00, 8'hF2, 0, 3'd3, 0, 1));
        // New VBlank request coincident with the ack of VBlank
        tbl.push_back(v(A_IF, 8'h00, 1, 0, 0, 0, 0, 0, 5'h00, 8'hF2, 0, 3'd3, 0, 1));
        tbl.push_back(v(A_IE, 8'h01, 1, 0, 0, 0, 0, 0, 5'h00, 8'h10, 0, 3'd3, 0, 0));
        tbl.push_back(v(A_IF, 8'h00, 0, 0, 0, 0, 0, 0, 5'h01, 8'hE0, 0, 3'd3, 0, 0));
        tbl.push_back(v(A_IF, 8'h00, 0, 0, 0, 1, 0, 0, 5'h00, 8'hE1, 0, 3'd3, 0, 1));
        tbl.push_back(v(A_IF, 8'h00, 0, 0, 0, 0, 1, 0, 5'h00, 8'hE1, 0, 3'd3, 1, 1));
        tbl.push_back(v(A_IF, 8'h00, 0, 0, 0, 0, 0, 1, 5'h01, 8'hE1, 1, 3'd0, 1, 1));
        tbl.push_back(v(A_IF, 8'h00, 0, 0, 0, 0, 0, 0, 5'h00, 8'hE1, 0, 3'd0, 0, 1));
        tbl.push_back(v(A_IF, 8'h00, 0, 0, 0, 1, 0, 0, 5'h00, 8'hE1, 0, 3'd0, 0, 1));
        tbl.push_back(v(A_IF, 8'h00, 0, 0, 0, 0, 0, 0, 5'h00, 8'hE1, 0, 3'd0, 1, 1));
        tbl.push_back(v(A_IF, 8'h00, 0, 0, 0, 0, 1, 0, 5'h00, 8'hE1, 0, 3'd0, 1, 1));
        tbl.push_back(v(A_IF, 8'h00, 0, 0, 0, 0, 0, 0, 5'h00, 8'hE1, 1, 3'd0, 1, 1));
        tbl.push_back(v(A_IF, 8'h00, 0, 0, 0, 0, 0, 1, 5'h00, 8'hE1, 1, 3'd0, 1, 1));
        tbl.push_back(v(A_IF, 8'h00, 0, 0, 0, 0, 0, 0, 5'h00, 8'hE0, 0, 3'd0, 0, 0));
        // Halt wake with IME off; ei+di together; write and request together
        tbl.push_back(v(A_IF, 8'h00, 0, 0, 0, 0, 0, 0, 5'h01, 8'hE0, 0, 3'd0, 0, 0));
        tbl.push_back(v(A_IF, 8'h00, 0, 0, 0, 0, 0, 0, 5'h00, 8'hE1, 0, 3'd0, 0, 1));
        tbl.push_back(v(A_IF, 8'h00, 0, 1, 1, 0, 0, 0, 5'h00, 8'hE1, 0, 3'd0, 0, 1));
        tbl.push_back(v(A_IF, 8'h00, 0, 0, 0, 0, 1, 0, 5'h00, 8'hE1, 0, 3'd0, 0, 1));
        tbl.push_back(v(A_IF, 8'h00, 0, 0, 0, 0, 1, 0, 5'h00, 8'hE1, 0, 3'd0, 0, 1));
        tbl.push_back(v(A_IF, 8'h00, 1, 0, 0, 0, 0, 0, 5'h02, 8'hE1, 0, 3'd0, 0, 1));
        tbl.push_back(v(A_IF, 8'h00, 0, 0, 0, 0, 0, 0, 5'h00, 8'hE2, 0, 3'd0, 0, 0));
        tbl.push_back(v(16'h1234, 8'h00, 0, 0, 0, 0, 0, 0, 5'h00, 8'h00, 0, 3'd0, 0, 0));
        // Prepare STAT dispatch for the reset sequence below
        tbl.push_back(v(A_IE, 8'h02, 1, 0, 0, 0, 0, 0, 5'h00, 8'h01, 0, 3'd0, 0, 0));
        tbl.push_back(v(A_IF, 8'h00, 0, 0, 0, 1, 0, 0, 5'h00, 8'hE2, 0, 3'd0, 0, 1));
        tbl.push_back(v(A_IF, 8'h00, 0, 0, 0, 0, 1, 0, 5'h00, 8'hE2, 0, 3'd0, 1, 1));

        drive_idle();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("row%0d", i));

        // Bounded wait for the STAT dispatch, then asynchronous reset mid-cycle.
        @(negedge clock);
        drive_idle();
        got = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (int_request) begin
                got = 1'b1;
                break;
            end
            @(negedge clock);
        end
        check("dispatch seen within budget", 32'(got), 32'd1);
        check("dispatch index STAT", 32'(int_pc_out), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check("async reset int_request", 32'(int_request), 32'd0);
        check("async reset ime", 32'(ime), 32'd0);
        check("async reset int_pc_out", 32'(int_pc_out), 32'd0);
        check("async reset IF read", 32'(data_out), 32'hE0);
        addr_bus = A_IE;
        #1;
        check("async reset IE read", 32'(data_out), 32'h00);
        @(negedge clock);
        reset = 1'b1;
        apply(v(A_IF, 8'h00, 0, 0, 0, 0, 1, 0, 5'h00, 8'hE0, 0, 3'd0, 0, 0), "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
